// File: rtl/tlb_lookup_arbiter_pkg.sv
// Shared definitions for the TLB lookup arbiter: requester IDs, the
// starvation-limit default and the captured lookup result record.
package tlb_lookup_arbiter_pkg;

   localparam int NUM_REQ          = 3;
   localparam int STARVE_LIMIT_DEF = 4;

   // Requester ID; also the bit position of each requester in req/gnt vectors.
   typedef enum logic [1:0] {
      REQ_INST  = 2'd0,
      REQ_DATA  = 2'd1,
      REQ_PROBE = 2'd2
   } req_id_e;

   // Lookup result as captured for inst/data responders.
   typedef struct packed {
      logic [31:0] paddr;
      logic        miss;
      logic        invalid;
      logic [2:0]  cattr;
   } xlat_rsp_t;

endpackage

// File: rtl/tlb_arb_prio.sv
// Combinational 3-way priority picker: probe > data > inst, with a
// starvation override that lifts inst above data (probe stays highest).
module tlb_arb_prio
   import tlb_lookup_arbiter_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic               starve,
   output logic [NUM_REQ-1:0] gnt,
   output req_id_e            winner
);

   // Pick exactly one eligible requester; idle defaults point at probe so the
   // TLB address mux shows probe_vaddr when nothing is granted.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      gnt    = '0;
      winner = REQ_PROBE;
      if (req[REQ_PROBE]) begin
         gnt[REQ_PROBE] = 1'b1;
         winner         = REQ_PROBE;
      end else if (starve && req[REQ_INST]) begin
         gnt[REQ_INST] = 1'b1;
         winner        = REQ_INST;
      end else if (req[REQ_DATA]) begin
         gnt[REQ_DATA] = 1'b1;
         winner        = REQ_DATA;
      end else if (req[REQ_INST]) begin
         gnt[REQ_INST] = 1'b1;
         winner        = REQ_INST;
      end
   end

endmodule

// File: rtl/tlb_lookup_arbiter.sv
// Shares the TLB lookup port between inst fetch, data access and TLBP probe.
// Grants combinationally, registers the TLB result for the winner one cycle
// later. Optional fairness: define TLB_ARB_FAIR_EN to enable the inst
// starvation counter; without it arbitration is pure fixed priority.
module tlb_lookup_arbiter
   import tlb_lookup_arbiter_pkg::*;
#(
   parameter int IDX_W        = 5,
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             inst_req,
   input  logic             data_req,
   input  logic             probe_req,
   input  logic [31:0]      inst_vaddr,
   input  logic [31:0]      data_vaddr,
   input  logic [31:0]      probe_vaddr,
   input  logic             data_wr,
   output logic             inst_gnt,
   output logic             data_gnt,
   output logic             probe_gnt,
   output logic             inst_rsp_valid,
   output logic             data_rsp_valid,
   output logic             probe_rsp_valid,
   output logic [31:0]      inst_rsp_paddr,
   output logic [31:0]      data_rsp_paddr,
   output logic             inst_rsp_miss,
   output logic             data_rsp_miss,
   output logic             probe_rsp_miss,
   output logic             inst_rsp_invalid,
   output logic             data_rsp_invalid,
   output logic             data_rsp_modified,
   output logic [2:0]       inst_rsp_cattr,
   output logic [2:0]       data_rsp_cattr,
   output logic [IDX_W-1:0] probe_rsp_index,
   output logic [31:0]      tlb_vaddr,
   input  logic [31:0]      tlb_paddr,
   input  logic             tlb_miss,
   input  logic             tlb_invalid,
   input  logic             tlb_dirty,
   input  logic [2:0]       tlb_cattr,
   input  logic [IDX_W-1:0] tlb_index,
   input  logic             tlb_write,
   input  logic             flush_i,
   output logic [31:0]      perfcnt_tlb_conflict
);

   logic [NUM_REQ-1:0] req_vec;
   logic [NUM_REQ-1:0] elig;
   logic [NUM_REQ-1:0] gnt;
   req_id_e            winner;
   logic               starve;
   logic               conflict;
   xlat_rsp_t          xlat_now;
   logic               modified_now;

   // A TLB write freezes arbitration so no lookup sees a half-written entry set.
   assign req_vec = {probe_req, data_req, inst_req};
   assign elig    = req_vec & {NUM_REQ{~tlb_write}};

   tlb_arb_prio u_prio (
      .req    (elig),
      .starve (starve),
      .gnt    (gnt),
      .winner (winner)
   );

   assign inst_gnt  = gnt[REQ_INST];
   assign data_gnt  = gnt[REQ_DATA];
   assign probe_gnt = gnt[REQ_PROBE];

   // Present the winner's address to the TLB; probe_vaddr when idle.
   always_comb begin
      tlb_vaddr = probe_vaddr;
      case (winner)
         REQ_INST: tlb_vaddr = inst_vaddr;
         REQ_DATA: tlb_vaddr = data_vaddr;
         default:  tlb_vaddr = probe_vaddr;
      endcase
   end

   assign xlat_now     = '{paddr: tlb_paddr, miss: tlb_miss, invalid: tlb_invalid, cattr: tlb_cattr};
   assign modified_now = data_wr & ~tlb_dirty & ~tlb_miss & ~tlb_invalid;
   assign conflict     = (inst_req & data_req) | (inst_req & probe_req) | (data_req & probe_req);

`ifdef TLB_ARB_FAIR_EN
   localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);
   logic [2:0] starve_cnt;

   // Count write-free cycles in which a waiting inst request lost; saturate at the limit.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!resetn) begin
         starve_cnt <= '0;
      end else if (!inst_req || inst_gnt) begin
         starve_cnt <= '0;
      end else if (!tlb_write && (starve_cnt < STARVE_MAX)) begin
         starve_cnt <= starve_cnt + 3'd1;
      end
   end

   assign starve = inst_req && (starve_cnt >= STARVE_MAX);
`else
   logic unused_starve_limit;
   assign unused_starve_limit = (STARVE_LIMIT != 0);
   assign starve              = 1'b0;
`endif

   // Capture the TLB result for the winner; valid pulses one cycle, data holds.
   // Flush masks inst/data valid only; the probe is the committing instruction.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         inst_rsp_valid    <= 1'b0;
         data_rsp_valid    <= 1'b0;
         probe_rsp_valid   <= 1'b0;
         inst_rsp_paddr    <= '0;
         inst_rsp_miss     <= 1'b0;
         inst_rsp_invalid  <= 1'b0;
         inst_rsp_cattr    <= '0;
         data_rsp_paddr    <= '0;
         data_rsp_miss     <= 1'b0;
         data_rsp_invalid  <= 1'b0;
         data_rsp_cattr    <= '0;
         data_rsp_modified <= 1'b0;
         probe_rsp_miss    <= 1'b0;
         probe_rsp_index   <= '0;
      end else begin
         inst_rsp_valid  <= inst_gnt & ~flush_i;
         data_rsp_valid  <= data_gnt & ~flush_i;
         probe_rsp_valid <= probe_gnt;
         if (inst_gnt) begin
            inst_rsp_paddr   <= xlat_now.paddr;
            inst_rsp_miss    <= xlat_now.miss;
            inst_rsp_invalid <= xlat_now.invalid;
            inst_rsp_cattr   <= xlat_now.cattr;
         end
         if (data_gnt) begin
            data_rsp_paddr    <= xlat_now.paddr;
            data_rsp_miss     <= xlat_now.miss;
            data_rsp_invalid  <= xlat_now.invalid;
            data_rsp_cattr    <= xlat_now.cattr;
            data_rsp_modified <= modified_now;
         end
         if (probe_gnt) begin
            probe_rsp_miss  <= tlb_miss;
            probe_rsp_index <= tlb_index;
         end
      end
   end

   // Count cycles with two or more raw requests pending, writes included.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         perfcnt_tlb_conflict <= '0;
      end else if (conflict) begin
         perfcnt_tlb_conflict <= perfcnt_tlb_conflict + 32'd1;
      end
   end

endmodule
